div5_seq: RTL and testbench

Sequential divide-by-5 controller for two 5-bit operands. It loads two operands, then drives the step ALU (fixed ±5 unit, `ALUop`/`iseq` interface) one subtraction per cycle. It consumes the ALU's `res`/`sign` to form quotient and remainder for each operand. It sits directly upstream and downstream of the ALU: its `alu_*` outputs connect to the ALU inputs, and the ALU's outputs come back on `alu_res`/`alu_sign`.

---
 rtl/div5_seq_pkg.sv | 21 ++
 rtl/div5_seq_if.sv | 31 +++
 rtl/div5_seq_qcnt3.sv | 20 ++
 rtl/div5_seq.sv | 131 +++++++++++++
 tb/tb_div5_seq.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/div5_seq_pkg.sv
// Shared constants and FSM encoding for the divide-by-5 sequencer and its step ALU.
package div5_seq_pkg;

    localparam int SIZE = 5;
    localparam int QW   = 3;
    localparam int STEP = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUB_A = 2'd1,
        SUB_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_SUB  = 1'b0;
    localparam logic OP_ADD  = 1'b1;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/div5_seq_if.sv
// Request/result handshake plus the ALU-facing signals of the divide-by-5 sequencer.
interface div5_seq_if;
    import div5_seq_pkg::*;

    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            busy;
    logic            done;
    logic [QW-1:0]   qa;
    logic [QW-1:0]   ra;
    logic [QW-1:0]   qb;
    logic [QW-1:0]   rb;
    logic [SIZE-1:0] alu_in1;
    logic [SIZE-1:0] alu_in2;
    logic            alu_op;
    logic            alu_iseq;
    logic [SIZE:0]   alu_res;
    logic            alu_sign;

    modport slave (
        input  start, a, b, alu_res, alu_sign,
        output busy, done, qa, ra, qb, rb, alu_in1, alu_in2, alu_op, alu_iseq
    );

    modport master (
        output start, a, b, alu_res, alu_sign,
        input  busy, done, qa, ra, qb, rb, alu_in1, alu_in2, alu_op, alu_iseq
    );

endinterface

// File: rtl/div5_seq_qcnt3.sv
// 3-bit quotient counter: synchronous clear on a new operation, increment per committed subtraction.
module qcnt3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 3'd0;
        end else if (clr) begin
            q <= 3'd0;
        end else if (inc) begin
            q <= q + 3'd1;
        end
    end

endmodule

// File: rtl/div5_seq.sv
// Divide-by-5 controller: repeatedly subtracts 5 from operand A then B through an external step ALU.
module div5_seq
    import div5_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    div5_seq_if.slave  bus
);

    state_t          state;
    state_t          nxt_state;
    logic [SIZE-1:0] reg_a;
    logic [SIZE-1:0] reg_b;
    logic [QW-1:0]   qa;
    logic [QW-1:0]   qb;
    logic [QW-1:0]   ra;
    logic [QW-1:0]   rb;
    logic            load;
    logic            inc_a;
    logic            inc_b;
    logic            cap_ra;
    logic            cap_rb;

    // Only the sign output steers the FSM; the ALU result MSB duplicates it.
    logic            res_msb_unused;
    assign res_msb_unused = bus.alu_res[SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        load      = 1'b0;
        inc_a     = 1'b0;
        inc_b     = 1'b0;
        cap_ra    = 1'b0;
        cap_rb    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    nxt_state = SUB_A;
                end
            end
            SUB_A: begin
                if (bus.alu_sign) begin
                    cap_ra    = 1'b1;
                    nxt_state = SUB_B;
                end else begin
                    inc_a = 1'b1;
                end
            end
            SUB_B: begin
                if (bus.alu_sign) begin
                    cap_rb    = 1'b1;
                    nxt_state = DONE;
                end else begin
                    inc_b = 1'b1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // A negative ALU result is never written back, so the working registers stay in 0..31.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a <= '0;
            reg_b <= '0;
            ra    <= '0;
            rb    <= '0;
        end else begin
            if (load) begin
                reg_a <= bus.a;
                reg_b <= bus.b;
                ra    <= '0;
                rb    <= '0;
            end
            if (inc_a) begin
                reg_a <= bus.alu_res[SIZE-1:0];
            end
            if (inc_b) begin
                reg_b <= bus.alu_res[SIZE-1:0];
            end
            if (cap_ra) begin
                ra <= reg_a[QW-1:0];
            end
            if (cap_rb) begin
                rb <= reg_b[QW-1:0];
            end
        end
    end

    qcnt3 u_qcnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (inc_a),
        .q     (qa)
    );

    qcnt3 u_qcnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (inc_b),
        .q     (qb)
    );

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.alu_iseq = (state == SUB_B) ? SEL_IN2 : SEL_IN1;
    assign bus.alu_op   = OP_SUB;
    assign bus.alu_in1  = reg_a;
    assign bus.alu_in2  = reg_b;
    assign bus.qa       = qa;
    assign bus.ra       = ra;
    assign bus.qb       = qb;
    assign bus.rb       = rb;

endmodule

// File: tb/tb_div5_seq.sv
// Bench for div5_seq with a behavioural +/-5 step ALU beside it and an arithmetic reference model.
module tb_div5_seq;
    import div5_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   prev_qa, prev_ra, prev_qb, prev_rb;

    div5_seq_if bus ();

    div5_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Step ALU: fixed +/-5 on the selected operand, result one bit wider than the operand.
    logic [SIZE-1:0] alu_sel;
    always_comb begin
        alu_sel = bus.alu_iseq ? bus.alu_in2 : bus.alu_in1;
        if (bus.alu_op == OP_ADD) begin
            bus.alu_res = {1'b0, alu_sel} + (SIZE+1)'(STEP);
        end else begin
            bus.alu_res = {1'b0, alu_sel} - (SIZE+1)'(STEP);
        end
        bus.alu_sign = bus.alu_res[SIZE];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from the accepting cycle (cycle 0) to the done cycle; leaves the bench
    // at the following cycle. extra: cycle at which a spurious start is pulsed (0 = none).
    task automatic run_op(input int va, input int vb, input int extra, input bit hold);
        int eqa, era, eqb, erb, lat;
        eqa = va / 5;
        era = va % 5;
        eqb = vb / 5;
        erb = vb % 5;
        lat = eqa + eqb + 3;

        check("idle_busy", int'(bus.busy), 0);
        check("idle_done", int'(bus.done), 0);
        check("hold_qa", int'(bus.qa), prev_qa);
        check("hold_rb", int'(bus.rb), prev_rb);
        bus.start = 1'b1;
        bus.a     = SIZE'(va);
        bus.b     = SIZE'(vb);
        tick();
        for (int n = 1; n <= lat; n++) begin
            bus.start = hold || (n == extra);
            bus.a     = SIZE'($urandom);
            bus.b     = SIZE'($urandom);
            check("busy", int'(bus.busy), 1);
            check("done", int'(bus.done), (n == lat) ? 1 : 0);
            if (n == eqa + 1) begin
                check("last_suba_in1", int'(bus.alu_in1), era);
                check("iseq_a", int'(bus.alu_iseq), 0);
            end
            if (n == eqa + 2) begin
                check("iseq_b", int'(bus.alu_iseq), 1);
            end
            if (n == lat) begin
                check("qa", int'(bus.qa), eqa);
                check("ra", int'(bus.ra), era);
                check("qb", int'(bus.qb), eqb);
                check("rb", int'(bus.rb), erb);
                check("alu_op", int'(bus.alu_op), 0);
            end else begin
                tick();
            end
        end
        bus.start = hold;
        prev_qa = eqa;
        prev_ra = era;
        prev_qb = eqb;
        prev_rb = erb;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        prev_qa   = 0;
        prev_ra   = 0;
        prev_qb   = 0;
        prev_rb   = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_q", int'({bus.qa, bus.ra, bus.qb, bus.rb}), 0);
        check("rst_in", int'({bus.alu_in1, bus.alu_in2}), 0);
        check("rst_sel", int'({bus.alu_iseq, bus.alu_op}), 0);
        rst_n = 1'b1;
        tick();

        run_op(23, 7, 0, 1'b0);
        run_op(0, 4, 0, 1'b0);
        run_op(31, 31, 0, 1'b0);
        run_op(5, 10, 3, 1'b0);

        // Asynchronous reset in the middle of SUB_A.
        bus.start = 1'b1;
        bus.a     = SIZE'(20);
        bus.b     = SIZE'(20);
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_q", int'({bus.qa, bus.ra, bus.qb, bus.rb}), 0);
        check("mid_rst_in", int'({bus.alu_in1, bus.alu_in2}), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", int'(bus.done), 0);
            check("post_rst_busy", int'(bus.busy), 0);
        end
        prev_qa = 0;
        prev_ra = 0;
        prev_qb = 0;
        prev_rb = 0;
        run_op(20, 20, 0, 1'b0);

        // Continuous start: back-to-back operations every qa+qb+4 cycles.
        for (int k = 0; k < 3; k++) begin
            run_op(9, 3, 0, 1'b1);
        end
        bus.start = 1'b0;
        tick();

        for (int k = 0; k < 25; k++) begin
            int ra_v, rb_v, ex;
            ra_v = int'($urandom_range(0, 31));
            rb_v = int'($urandom_range(0, 31));
            ex   = int'($urandom_range(0, 6));
            run_op(ra_v, rb_v, ex, ($urandom_range(0, 3) == 0));
        end
        bus.start = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
